vec_mean_reduce_seq: RTL
========================

Name: vec_mean_reduce_seq

Overview:
- Sequencer that computes the truncated mean of an N-element signed vector.
- Time-shares a single truncated-average datapath: each operation computes s = a + b + cin at W+1 bits and returns s[W:1].
- Performs a pairwise tree reduction over log2(N) levels, N-1 adder operations in total.
- Sits in the vector unit between the operand register file and the scalar result bus. Uses valid/ready handshakes on both sides.

Parameters:
- W, 8, element width in bits (signed two's complement).
- N, 8, number of elements; must be a power of two, N >= 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  source presents a vector.
- in_ready  output  1  block can accept a vector; high only in IDLE.
- vec_in  input  N*W  packed vector; element i is vec_in[i*W+W-1 : i*W].
- round_en  input  1  carry-in for every adder operation of this job; sampled at accept.
- out_valid  output  1  result available.
- out_ready  input  1  sink accepts the result.
- result  output  W  reduced mean.
- busy  output  1  high in REDUCE or DONE.

Behaviour:
- Reset (async, immediate): state = IDLE, in_ready = 1, out_valid = 0, busy = 0, result = 0, all scratch elements = 0, level = 0, idx = 0, latched round bit = 0.
- Reset mid-operation aborts the job with no output; there is no partial result.
- FSM has three states: IDLE, REDUCE, DONE.
- IDLE:
  - Accept occurs on in_valid && in_ready.
  - On accept: latch all N elements of vec_in into scratch[0..N-1], latch round_en, set level = 0 and idx = 0, go to REDUCE.
  - in_valid without accept has no effect.
- REDUCE (one adder operation per cycle):
  - Operands: a = scratch[2*idx], b = scratch[2*idx+1], cin = latched round bit.
  - Sum: s = sext(a) + sext(b) + cin at W+1 bits. Written value: scratch[idx] <= s[W:1] (floor of (a+b+cin)/2).
  - The result never overflows W bits.
  - When idx == (N >> (level+1)) - 1: set idx = 0 and increment level. Otherwise increment idx.
  - When the operation at level log2(N)-1 completes, result <= s[W:1] and go to DONE.
  - In-place writes are safe: index idx is written only after 2*idx and 2*idx+1 have been read.
- DONE:
  - out_valid = 1; result holds stable.
  - On out_ready, go to IDLE; out_valid drops on the next cycle.
  - out_valid stays high indefinitely while out_ready = 0.
- Latency: with the accept at edge 0, N-1 operations occur on edges 1..N-1, and out_valid is high after edge N-1 (7 cycles for N = 8).
- Minimum initiation interval is N+1 cycles, including the DONE handshake cycle.
- in_ready = 0 in REDUCE and DONE; in_valid is ignored there, and vec_in/round_en changes have no effect.
- A new accept in the same cycle as the DONE handshake is not possible; the block returns to IDLE first.
- result retains its last value in IDLE until the next job completes or reset.
- Scratch and counters are registers. The adder is combinational and there is exactly one instance.

Test Plan:
- Reset then idle: after rst release, in_ready = 1, out_valid = 0, result = 0x00, busy = 0.
- All elements 0x7F, round_en = 0 -> result 0x7F, out_valid exactly 7 cycles after the accept edge. All elements 0x80 -> result 0x80.
- vec_in elements e0..e7 = 0x7F, 0x01, 0x80, 0xFF, 0, 0, 0, 0 with round_en = 0:
  - Level 0 gives 0x40, 0xBF, 0x00, 0x00.
  - Level 1 gives 0xFF, 0x00.
  - Result 0xFF.
- Rounding: e0 = 0x01, others 0.
  - round_en = 0 -> result 0x00.
  - round_en = 1 -> 0x01 at every level, result 0x01.
- Backpressure: complete a job with out_ready = 0 for 5 cycles -> out_valid and result stable, in_ready = 0, a toggling in_valid with a new vec_in is ignored. Then out_ready = 1 -> IDLE next cycle, in_ready = 1.
- Reset mid-operation: assert rst at the 3rd REDUCE cycle -> out_valid = 0, result = 0x00 immediately. After release, a new job with all elements 0x10 returns 0x10 with normal latency.

Source files
------------

// File: rtl/vec_mean_reduce_seq.sv
// Truncated-mean reducer for an N-element signed vector: one shared
// averaging adder, pairwise tree reduction over log2(N) levels, valid/ready on both sides.
module vec_mean_reduce_seq #(
  parameter int W = 8,
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] vec_in,
  input  logic           round_en,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   result,
  output logic           busy
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REDUCE,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_scratch [N];
  logic [IW-1:0] r_level;
  logic [IW-1:0] r_idx;
  logic          r_round;
  logic [W-1:0]  r_result;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_busy;

  logic [IW-1:0] w_a_sel;
  logic [IW-1:0] w_b_sel;
  logic [W-1:0]  w_a;
  logic [W-1:0]  w_b;
  logic [W:0]    w_sum;
  logic [W-1:0]  w_mean;
  logic [IW-1:0] w_last_idx;
  logic          w_level_end;
  logic          w_last_level;

  // Single shared adder: W+1-bit sum of sign-extended operands, keep the top W bits.
  always_comb begin
    w_a_sel      = r_idx << 1;
    w_b_sel      = w_a_sel | IW'(1);
    w_a          = r_scratch[w_a_sel];
    w_b          = r_scratch[w_b_sel];
    w_sum        = {w_a[W-1], w_a} + {w_b[W-1], w_b} + (W+1)'(r_round);
    w_mean       = w_sum[W:1];
    w_last_idx   = IW'((N >> (r_level + 1'b1)) - 1);
    w_level_end  = (r_idx == w_last_idx);
    w_last_level = (r_level == IW'(IW - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_level     <= '0;
      r_idx       <= '0;
      r_round     <= 1'b0;
      r_result    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        r_scratch[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            for (int unsigned i = 0; i < N; i++) begin
              r_scratch[i] <= vec_in[i*W +: W];
            end
            r_round    <= round_en;
            r_level    <= '0;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_REDUCE;
          end
        end

        S_REDUCE: begin
          // Slot idx is overwritten only after slots 2*idx and 2*idx+1 were consumed.
          r_scratch[r_idx] <= w_mean;
          if (w_level_end) begin
            r_idx   <= '0;
            r_level <= r_level + 1'b1;
            if (w_last_level) begin
              r_result    <= w_mean;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign result    = r_result;

endmodule
